// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word-only load/store sequencer with read-modify-write for sub-word stores
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              store_done,
    output logic              lsu_err,
    output logic [1:0]        lsu_err_cause
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_RD, S_LD_DONE, S_ST_WR, S_RMW_RD, S_RMW_WR, S_ERR
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cause_q, cause_d;

    logic ld_f3_ok, st_f3_ok, illegal, misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] merged;

    // Request classification; only ever feeds next-state, never an output directly.
    assign ld_f3_ok   = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign st_f3_ok   = req_funct3 inside {3'b000, 3'b001, 3'b010};
    assign illegal    = !(req_load ^ req_store)
                      || (req_load && !ld_f3_ok)
                      || (req_store && !st_f3_ok);
    assign misaligned = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
                      || ((req_funct3[1:0] == 2'b01) && req_addr[0]);

    // State and latched request; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            cause_q  <= cause_d;
        end
    end

    // Next state: a request is captured only in IDLE, everything else walks a fixed sequence.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        cause_d  = cause_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    cause_d  = 2'b00;
                    if (illegal) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = S_ERR;
                    end else if (misaligned) begin
                        cause_d = CAUSE_MISALIGNED;
                        state_d = S_ERR;
                    end else if (req_load) begin
                        state_d = S_LD_RD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_d = S_ST_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LD_RD:   state_d = S_LD_DONE;
            S_RMW_RD:  state_d = S_RMW_WR;
            default:   state_d = S_IDLE;
        endcase
    end

    // Lane extraction for loads and lane insertion for sub-word stores.
    always_comb begin
        byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        merged    = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Outputs decoded from state and latched request only.
    always_comb begin
        ready         = 1'b0;
        mem_addr      = '0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        load_valid    = 1'b0;
        load_data     = '0;
        store_done    = 1'b0;
        lsu_err       = 1'b0;
        lsu_err_cause = '0;
        if (state_q != S_IDLE) begin
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        end
        case (state_q)
            S_IDLE: ready = 1'b1;
            S_LD_RD, S_RMW_RD: mem_re = 1'b1;
            S_LD_DONE: begin
                load_valid = 1'b1;
                case (funct3_q)
                    3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
                    3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
                    3'b100:  load_data = {24'h0, byte_lane};
                    3'b101:  load_data = {16'h0, half_lane};
                    default: load_data = mem_rdata;
                endcase
            end
            S_ST_WR: begin
                mem_we     = 1'b1;
                mem_wdata  = wdata_q;
                store_done = 1'b1;
            end
            S_RMW_WR: begin
                mem_we     = 1'b1;
                mem_wdata  = merged;
                store_done = 1'b1;
            end
            S_ERR: begin
                lsu_err       = 1'b1;
                lsu_err_cause = cause_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven scoreboard bench for load_store_unit
module tb_load_store_unit;

    localparam int KLD  = 0;
    localparam int KST  = 1;
    localparam int KERR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_load = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        ready;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        store_done, lsu_err;
    logic [1:0]  lsu_err_cause;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_load(req_load),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .ready(ready), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .load_valid(load_valid), .load_data(load_data),
        .store_done(store_done), .lsu_err(lsu_err), .lsu_err_cause(lsu_err_cause)
    );

    always #5 clk = ~clk;

    // Word memory with one-cycle registered read.
    logic [31:0] mem [0:15];
    logic        mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h8123_45F6;
            mem[3] <= 32'h1111_2222;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_re) mem_rdata <= mem[mem_addr[5:2]];
            if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          kind;
        logic [31:0] data;
        logic [1:0]  cause;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [1:0]  cause;
        int          a;
        int          lat;
        int          n_re;
        int          n_we;
        logic [31:0] waddr;
    } exp_t;

    vec_t vecs [24];
    exp_t sbq [$];

    int n_cmp = 0;
    int n_fail = 0;
    int re_seen = 0;
    int we_seen = 0;
    logic mon_off = 1'b0;
    logic have_prev = 1'b0;
    int prev_a = 0;
    int prev_rlat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setv(input int i, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int kind,
                        input logic [31:0] data, input logic [1:0] cause);
        vecs[i].ld = ld; vecs[i].st = st; vecs[i].f3 = f3; vecs[i].addr = addr;
        vecs[i].wdata = wd; vecs[i].kind = kind; vecs[i].data = data; vecs[i].cause = cause;
    endtask

    // Present one request as soon as ready, queue its expectation, then hold junk on the bus while busy.
    task automatic issue(input vec_t v);
        exp_t e;
        int   w = 0;
        @(negedge clk);
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            chk("ready_timeout", {31'b0, ready}, 32'h1);
            return;
        end
        if (have_prev) chk("ready_latency", cyc - prev_a, prev_rlat);
        req_valid = 1'b1; req_load = v.ld; req_store = v.st;
        req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        e.kind = v.kind; e.data = v.data; e.cause = v.cause; e.a = cyc;
        e.waddr = {v.addr[31:2], 2'b00};
        if (v.kind == KLD) begin
            e.lat = 2; e.n_re = 1; e.n_we = 0;
        end else if (v.kind == KST && v.f3 == 3'b010) begin
            e.lat = 1; e.n_re = 0; e.n_we = 1;
        end else if (v.kind == KST) begin
            e.lat = 2; e.n_re = 1; e.n_we = 1;
        end else begin
            e.lat = 1; e.n_re = 0; e.n_we = 0;
        end
        sbq.push_back(e);
        prev_a = cyc; prev_rlat = e.lat + 1; have_prev = 1'b1;
        @(posedge clk);
        #1;
        {req_load, req_store} = 2'($urandom_range(0, 3));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = 32'($urandom_range(0, 63));
        req_wdata  = $urandom;
    endtask

    // Output monitor: strobe exclusivity, idle-zero outputs and scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            re_seen <= 0;
            we_seen <= 0;
        end else if (!mon_off) begin
            int   nev;
            int   kind;
            exp_t e;
            int   re_n, we_n;
            re_n = re_seen + (mem_re ? 1 : 0);
            we_n = we_seen + (mem_we ? 1 : 0);
            if (mem_re && mem_we) chk("re_we_both", 32'h1, 32'h0);
            if (mem_re || mem_we) begin
                if (sbq.size() == 0) chk("stray_strobe", {30'b0, mem_re, mem_we}, 32'h0);
                else chk("mem_addr", mem_addr, sbq[0].waddr);
            end
            if (!mem_we) chk("wdata_idle", mem_wdata, 32'h0);
            if (!load_valid) chk("load_data_idle", load_data, 32'h0);
            if (!lsu_err) chk("cause_idle", {30'b0, lsu_err_cause}, 32'h0);
            if (ready) chk("mem_addr_idle", mem_addr, 32'h0);
            nev = int'(load_valid) + int'(store_done) + int'(lsu_err);
            if (nev > 1) chk("multi_event", nev, 1);
            if (nev >= 1) begin
                kind = load_valid ? KLD : (store_done ? KST : KERR);
                if (sbq.size() == 0) begin
                    chk("unexpected_output", kind, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("kind", kind, e.kind);
                    if (kind == KLD) chk("load_data", load_data, e.data);
                    if (kind == KST) chk("store_wdata", mem_wdata, e.data);
                    if (kind == KERR) chk("err_cause", {30'b0, lsu_err_cause}, {30'b0, e.cause});
                    chk("latency", cyc - e.a, e.lat);
                    chk("re_count", re_n, e.n_re);
                    chk("we_count", we_n, e.n_we);
                end
                re_n = 0;
                we_n = 0;
            end
            re_seen <= re_n;
            we_seen <= we_n;
        end
    end

    initial begin
        vec_t v;
        int   w;
        setv( 0, 1, 0, 3'b000, 32'h08, 32'h0,        KLD,  32'hFFFF_FFF6, 2'b00);
        setv( 1, 1, 0, 3'b100, 32'h0B, 32'h0,        KLD,  32'h0000_0081, 2'b00);
        setv( 2, 1, 0, 3'b001, 32'h0A, 32'h0,        KLD,  32'hFFFF_8123, 2'b00);
        setv( 3, 1, 0, 3'b101, 32'h08, 32'h0,        KLD,  32'h0000_45F6, 2'b00);
        setv( 4, 1, 0, 3'b010, 32'h08, 32'h0,        KLD,  32'h8123_45F6, 2'b00);
        setv( 5, 0, 1, 3'b000, 32'h09, 32'h0000_00AA, KST, 32'h8123_AAF6, 2'b00);
        setv( 6, 1, 0, 3'b010, 32'h08, 32'h0,        KLD,  32'h8123_AAF6, 2'b00);
        setv( 7, 0, 1, 3'b001, 32'h0E, 32'h0000_BEEF, KST, 32'hBEEF_2222, 2'b00);
        setv( 8, 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, KST, 32'hDEAD_BEEF, 2'b00);
        setv( 9, 1, 0, 3'b010, 32'h10, 32'h0,        KLD,  32'hDEAD_BEEF, 2'b00);
        setv(10, 1, 0, 3'b010, 32'h06, 32'h0,        KERR, 32'h0,         2'b01);
        setv(11, 0, 1, 3'b001, 32'h03, 32'h1234,     KERR, 32'h0,         2'b01);
        setv(12, 1, 0, 3'b011, 32'h00, 32'h0,        KERR, 32'h0,         2'b10);
        setv(13, 1, 1, 3'b010, 32'h02, 32'h0,        KERR, 32'h0,         2'b10);
        setv(14, 0, 0, 3'b000, 32'h00, 32'h0,        KERR, 32'h0,         2'b10);
        setv(15, 1, 0, 3'b000, 32'h0F, 32'h0,        KLD,  32'hFFFF_FFBE, 2'b00);
        setv(16, 1, 0, 3'b100, 32'h0D, 32'h0,        KLD,  32'h0000_0022, 2'b00);
        setv(17, 0, 1, 3'b000, 32'h0C, 32'h1234_5677, KST, 32'hBEEF_2277, 2'b00);
        setv(18, 1, 0, 3'b101, 32'h0E, 32'h0,        KLD,  32'h0000_BEEF, 2'b00);
        setv(19, 0, 1, 3'b010, 32'h12, 32'h5555_5555, KERR, 32'h0,        2'b01);
        setv(20, 1, 0, 3'b001, 32'h0E, 32'h0,        KLD,  32'hFFFF_BEEF, 2'b00);
        setv(21, 0, 1, 3'b100, 32'h04, 32'h0,        KERR, 32'h0,         2'b10);
        setv(22, 1, 0, 3'b101, 32'h05, 32'h0,        KERR, 32'h0,         2'b01);
        setv(23, 1, 0, 3'b000, 32'h0E, 32'h0,        KLD,  32'hFFFF_FFEF, 2'b00);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_strobes", {27'b0, mem_re, mem_we, load_valid, store_done, lsu_err}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        mem_init = 1'b0;

        for (int i = 0; i < 24; i++) issue(vecs[i]);

        // Reset during the read phase of a byte store: the write must never appear.
        @(negedge clk);
        w = 0;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        mon_off = 1'b1;
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
        req_funct3 = 3'b000; req_addr = 32'h09; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rd_re", {31'b0, mem_re}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'h1);
        chk("midrst_strobes", {27'b0, mem_re, mem_we, load_valid, store_done, lsu_err}, 32'h0);
        chk("midrst_data", mem_addr | mem_wdata | load_data | {30'b0, lsu_err_cause}, 32'h0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        have_prev = 1'b0;
        mon_off = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_we", we_seen, 0);
        chk("post_rst_mem", mem[2], 32'h8123_AAF6);
        v.ld = 1; v.st = 0; v.f3 = 3'b010; v.addr = 32'h08; v.wdata = 0;
        v.kind = KLD; v.data = 32'h8123_AAF6; v.cause = 2'b00;
        issue(v);
        req_valid = 1'b0;

        w = 0;
        while (sbq.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sbq.size(), 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencing stage between the EX/MEM pipeline register and the data memory. Accepts one load or store per request, converts it into word-only memory transactions, and performs read-modify-write for byte/half stores. Sign- or zero-extends load data and flags misaligned or illegal accesses. Holds the pipeline via `ready` while a transaction is in flight.

## Interface
- `ADDR_W`, 32, request/memory address width
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present (sampled only when `ready`=1)
- `req_load`  in  1  request is a load
- `req_store`  in  1  request is a store
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data (low byte/half used for SB/SH)
- `ready`  out  1  idle, can accept a request this cycle
- `mem_addr`  out  ADDR_W  word-aligned address, `{req_addr[ADDR_W-1:2],2'b00}`
- `mem_re`  out  1  memory read strobe
- `mem_we`  out  1  memory write strobe
- `mem_wdata`  out  32  full-word write data
- `mem_rdata`  in  32  registered memory read data, valid cycle after `mem_re`
- `load_valid`  out  1  one-cycle pulse, `load_data` valid
- `load_data`  out  32  extended load result
- `store_done`  out  1  one-cycle pulse with final write strobe
- `lsu_err`  out  1  one-cycle pulse, request rejected
- `lsu_err_cause`  out  2  01 misaligned, 10 illegal (valid with `lsu_err`)

## Operation
- Request latched (addr, funct3, wdata, type) on the accepting edge; upstream need not hold it afterwards.
- Memory port is word-only: half/byte selection never delegated to memory.
- States: IDLE, LD_RD, LD_DONE, ST_WR, RMW_RD, RMW_WR, ERR.
- IDLE: `ready`=1. On `req_valid`: illegal → ERR; misaligned → ERR; load → LD_RD; SW → ST_WR; SB/SH → RMW_RD. No request → stay.
- Illegal: both or neither of `req_load`/`req_store`; load funct3 011/110/111; store funct3 not in 000/001/010. Illegal takes precedence over misaligned.
- Misaligned: W with `addr[1:0]`≠0; H/HU/SH with `addr[0]`=1.
- LD_RD: `mem_re`=1 → LD_DONE.
- LD_DONE: `load_valid`=1, `load_data` from `mem_rdata` lane: byte lane `addr[1:0]` (bits 8k+7:8k), half lane `addr[1]` (bits 31:16 if 1); B/H sign-extend from lane MSB, BU/HU zero-extend, W pass-through → IDLE.
- ST_WR: `mem_we`=1, `mem_wdata`=`req_wdata`, `store_done`=1 → IDLE.
- RMW_RD: `mem_re`=1 → RMW_WR.
- RMW_WR: `mem_we`=1, `mem_wdata`=`mem_rdata` with addressed lane replaced by `req_wdata[7:0]` (SB) or `req_wdata[15:0]` (SH), other lanes unchanged; `store_done`=1 → IDLE.
- ERR: `lsu_err`=1, cause driven, no memory strobe → IDLE.
- `mem_re` and `mem_we` never both 1. `mem_addr` is the latched word address in every non-IDLE state, 0 in IDLE.
- `req_valid` while `ready`=0 is ignored (not queued).

## Timing
- Reset (async, any state): state→IDLE; `ready`=1; `mem_re`, `mem_we`, `load_valid`, `store_done`, `lsu_err`=0; `load_data`, `mem_wdata`, `mem_addr`, `lsu_err_cause`=0; latched request cleared. A strobe in progress is dropped; no write issued after reset deasserts.
- All outputs decoded from state + latched request only; no combinational path from `req_*` to any output except none (`ready` is state-only).
- Accept at edge T: load → `mem_re` cycle T+1, `load_valid` T+2, `ready` again T+3.
- SW → `mem_we` T+1, `ready` T+2. SB/SH → `mem_re` T+1, `mem_we` T+2, `ready` T+3.
- Error → `lsu_err` T+1, `ready` T+2.
- Outside LD_DONE `load_data`=0; outside ERR `lsu_err_cause`=0; outside write states `mem_wdata`=0.
- Back-to-back: a request presented the cycle `ready` returns is accepted that cycle.

## Test plan
- Mem[0x8]=0x8123_45F6; LB addr 0x8 → `load_valid` 2 cycles after accept, `load_data`=0xFFFF_FFF6; LBU 0xB → 0x0000_0081; LH 0xA → 0xFFFF_8123; LHU 0x8 → 0x0000_45F6.
- SB addr 0x9 data 0xAA on Mem[0x8]=0x8123_45F6 → `mem_re` T+1, `mem_we` T+2 with 0x8123_AAF6, `store_done` T+2; subsequent LW 0x8 → 0x8123_AAF6.
- SH addr 0xE data 0xBEEF on Mem[0xC]=0x1111_2222 → write 0xBEEF_2222; SW 0x10 data 0xDEAD_BEEF → single `mem_we` T+1, no `mem_re`.
- LW 0x6, SH 0x3 → `lsu_err`=1 cause 01 at T+1, no strobes; load funct3 011 or load+store both high → cause 10.
- `rst` pulsed during RMW_RD of an SB → no `mem_we` ever, all outputs 0, `ready`=1 immediately; memory word unchanged.
- `req_valid` held high during busy cycles with changing data → only first request executed; next accepted exactly on `ready` return.
